// File: rtl/traffic_sensor_frontend.sv
// Sensor front end for the intersection controller: synchronises and debounces the loop
// detectors and preempt input, latches per-loop demand until served, and stretches emergency.
module traffic_sensor_frontend #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int SERVE_CYCLES    = 10,
  parameter int PREEMPT_HOLD    = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] loop_raw,
  input  logic       preempt_raw,
  input  logic [3:0] light,
  output logic [3:0] presence,
  output logic [3:0] traffic_sensors,
  output logic       emergency
);

  localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] SERVE_MAX = 8'(SERVE_CYCLES);
  localparam logic [7:0] HOLD_LOAD = 8'(PREEMPT_HOLD);
  localparam int         NCH       = 5;  // four loops plus preempt in bit 4

  logic [NCH-1:0] s1_q, s1_d, s2_q, s2_d, deb_q, deb_d;
  logic [7:0]     db_cnt_q [NCH];
  logic [7:0]     db_cnt_d [NCH];
  logic [7:0]     ns_cnt_q, ns_cnt_d, ew_cnt_q, ew_cnt_d;
  logic [3:0]     dem_q, dem_d;
  logic [7:0]     hold_q, hold_d;
  logic           emerg_q, emerg_d;
  logic           ns_green, ew_green, ns_served, ew_served;

  // Two-flop synchroniser followed by a per-channel stability counter.
  always_comb begin
    s1_d = {preempt_raw, loop_raw};
    s2_d = s1_q;
    deb_d = deb_q;
    for (int i = 0; i < NCH; i++) begin
      db_cnt_d[i] = 8'd0;
      if (s2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          deb_d[i] = s2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign ns_green  = (light == 4'b0001);
  assign ew_green  = (light == 4'b0100);
  assign ns_served = (ns_cnt_q == SERVE_MAX);
  assign ew_served = (ew_cnt_q == SERVE_MAX);

  always_comb begin
    ns_cnt_d = 8'd0;
    ew_cnt_d = 8'd0;
    if (ns_green) begin
      ns_cnt_d = ns_served ? ns_cnt_q : ns_cnt_q + 8'd1;
    end
    if (ew_green) begin
      ew_cnt_d = ew_served ? ew_cnt_q : ew_cnt_q + 8'd1;
    end
  end

  // Set wins over the lingering served flag on the first non-green cycle, so a vehicle
  // still present when green ends re-registers its call on the very next edge.
  always_comb begin
    dem_d = dem_q;
    for (int i = 0; i < 4; i++) begin
      if (i < 2) begin
        if (deb_q[i] && !ns_green) begin
          dem_d[i] = 1'b1;
        end else if (ns_served) begin
          dem_d[i] = 1'b0;
        end
      end else begin
        if (deb_q[i] && !ew_green) begin
          dem_d[i] = 1'b1;
        end else if (ew_served) begin
          dem_d[i] = 1'b0;
        end
      end
    end
  end

  // Emergency follows the next-state preempt so it rises and (with zero hold) falls with it.
  always_comb begin
    hold_d  = 8'd0;
    emerg_d = 1'b0;
    if (deb_d[4]) begin
      emerg_d = 1'b1;
    end else if (deb_q[4]) begin
      hold_d  = HOLD_LOAD;
      emerg_d = (HOLD_LOAD != 8'd0);
    end else if (hold_q != 8'd0) begin
      hold_d  = hold_q - 8'd1;
      emerg_d = (hold_q != 8'd1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      deb_q    <= '0;
      ns_cnt_q <= 8'd0;
      ew_cnt_q <= 8'd0;
      dem_q    <= 4'd0;
      hold_q   <= 8'd0;
      emerg_q  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        db_cnt_q[i] <= 8'd0;
      end
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      deb_q    <= deb_d;
      ns_cnt_q <= ns_cnt_d;
      ew_cnt_q <= ew_cnt_d;
      dem_q    <= dem_d;
      hold_q   <= hold_d;
      emerg_q  <= emerg_d;
      for (int i = 0; i < NCH; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign presence        = deb_q[3:0];
  assign traffic_sensors = dem_q;
  assign emergency       = emerg_q;

endmodule
